// File: rtl/mult_seq_ctrl.sv
//==============================================================================
// Module      : mult_seq_ctrl
// Description : Signed 8x8 multiply sequencer with a multiplier handshake,
//               double-dabble BCD conversion and a display scroll window.
//               Optional macro BLANK_LEADING_ZERO_EN blanks leading zero digits.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module mult_seq_ctrl #(
    parameter int TIMEOUT = 63
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        SL,
    input  logic        SR,
    input  logic [7:0]  plicand,
    input  logic [7:0]  pliar,
    output logic [7:0]  m_a,
    output logic [7:0]  m_b,
    output logic        m_start,
    input  logic [15:0] m_product,
    input  logic        m_done,
    output logic        busy,
    output logic        done,
    output logic        sign,
    output logic [19:0] bcd,
    output logic        scroll,
    output logic        err
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_CONV  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [7:0]  r_opa;
    logic [7:0]  r_opb;
    logic [7:0]  r_wait_cnt;
    logic [15:0] r_bin;
    logic [19:0] r_dd;
    logic [3:0]  r_bit_cnt;

    logic        w_start_ok;
    logic [8:0]  w_wait_inc;
    logic        w_timeout;
    logic [19:0] w_dd_adj;
    logic [19:0] w_dd_nxt;
    logic [15:0] w_bin_nxt;

    // Display formatting applied to every result loaded into bcd.
    function automatic logic [19:0] f_fmt(input logic [19:0] v);
        logic [19:0] res;
        res = v;
`ifdef BLANK_LEADING_ZERO_EN
        begin
            logic lead;
            lead = 1'b1;
            for (int i = 4; i >= 1; i--) begin
                if (lead && (v[4*i +: 4] == 4'd0)) begin
                    res[4*i +: 4] = 4'hF;
                end else begin
                    lead = 1'b0;
                end
            end
        end
`endif
        return res;
    endfunction

    assign w_start_ok = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_wait_inc = {1'b0, r_wait_cnt} + 9'd1;
    assign w_timeout  = (w_wait_inc == 9'(TIMEOUT));

    always_comb begin
        w_dd_adj = r_dd;
        for (int i = 0; i < 5; i++) begin
            if (r_dd[4*i +: 4] >= 4'd5) begin
                w_dd_adj[4*i +: 4] = r_dd[4*i +: 4] + 4'd3;
            end
        end
        {w_dd_nxt, w_bin_nxt} = {w_dd_adj, r_bin} << 1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE,
            S_DONE:  if (start) w_state_nxt = S_LOAD;
            S_LOAD:  w_state_nxt = S_ISSUE;
            S_ISSUE: w_state_nxt = S_WAIT;
            S_WAIT: begin
                if (m_done)         w_state_nxt = S_CONV;
                else if (w_timeout) w_state_nxt = S_DONE;
            end
            S_CONV:  if (r_bit_cnt == 4'd15) w_state_nxt = S_DONE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_opa      <= 8'd0;
            r_opb      <= 8'd0;
            r_wait_cnt <= 8'd0;
            r_bin      <= 16'd0;
            r_dd       <= 20'd0;
            r_bit_cnt  <= 4'd0;
            m_a        <= 8'd0;
            m_b        <= 8'd0;
            m_start    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            sign       <= 1'b0;
            bcd        <= 20'd0;
            scroll     <= 1'b0;
            err        <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE,
                S_DONE: begin
                    if (start) begin
                        r_opa <= plicand;
                        r_opb <= pliar;
                        err   <= 1'b0;
                        bcd   <= 20'd0;
                    end
                end
                S_LOAD: begin
                    // -128 negates to itself, which reads correctly as 0x80 unsigned.
                    m_a  <= r_opa[7] ? (~r_opa + 8'd1) : r_opa;
                    m_b  <= r_opb[7] ? (~r_opb + 8'd1) : r_opb;
                    sign <= r_opa[7] ^ r_opb[7];
                end
                S_ISSUE: r_wait_cnt <= 8'd0;
                S_WAIT: begin
                    r_wait_cnt <= w_wait_inc[7:0];
                    if (m_done) begin
                        r_bin     <= m_product;
                        r_dd      <= 20'd0;
                        r_bit_cnt <= 4'd0;
                    end else if (w_timeout) begin
                        err  <= 1'b1;
                        bcd  <= f_fmt(20'd0);
                        sign <= 1'b0;
                    end
                end
                S_CONV: begin
                    r_bin     <= w_bin_nxt;
                    r_dd      <= w_dd_nxt;
                    r_bit_cnt <= r_bit_cnt + 4'd1;
                    if (r_bit_cnt == 4'd15) begin
                        bcd <= f_fmt(w_dd_nxt);
                        if (w_dd_nxt == 20'd0) sign <= 1'b0;
                    end
                end
                default: ;
            endcase

            m_start <= (w_state_nxt == S_ISSUE);
            busy    <= (w_state_nxt == S_LOAD) || (w_state_nxt == S_ISSUE) ||
                       (w_state_nxt == S_WAIT) || (w_state_nxt == S_CONV);
            done    <= (w_state_nxt == S_DONE);

            // A new run always opens on the low window, overriding SL/SR.
            if (w_start_ok)       scroll <= 1'b0;
            else if (SL && !SR)   scroll <= 1'b1;
            else if (SR && !SL)   scroll <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mult_seq_ctrl.sv
//==============================================================================
// Module      : tb_mult_seq_ctrl
// Description : Scoreboard bench for mult_seq_ctrl with a behavioural multiplier.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_mult_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, SL, SR;
    logic [7:0]  plicand, pliar;
    logic [7:0]  m_a, m_b;
    logic        m_start;
    logic [15:0] m_product;
    logic        m_done;
    logic        busy, done, sign, scroll, err;
    logic [19:0] bcd;

    always #5 clk = ~clk;

    mult_seq_ctrl #(.TIMEOUT(63)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .SL        (SL),
        .SR        (SR),
        .plicand   (plicand),
        .pliar     (pliar),
        .m_a       (m_a),
        .m_b       (m_b),
        .m_start   (m_start),
        .m_product (m_product),
        .m_done    (m_done),
        .busy      (busy),
        .done      (done),
        .sign      (sign),
        .bcd       (bcd),
        .scroll    (scroll),
        .err       (err)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [7:0]  ea;
        logic [7:0]  eb;
        logic        es;
        logic [19:0] ebcd;
        logic        eerr;
    } exp_t;

    exp_t scb[$];

    function automatic logic [19:0] exp_bcd(input int v);
        logic [19:0] r;
        int t;
        bit lead;
        t    = v;
        lead = 1'b1;
        for (int i = 0; i < 5; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
`ifdef BLANK_LEADING_ZERO_EN
        for (int i = 4; i >= 1; i--) begin
            if (lead && (r[4*i +: 4] == 4'd0)) r[4*i +: 4] = 4'hF;
            else lead = 1'b0;
        end
`endif
        return r;
    endfunction

    // Behavioural multiplier: answers mdl_delay cycles after m_start.
    int mdl_delay = 5;
    bit mdl_never = 1'b0;

    initial begin
        int p;
        m_done    = 1'b0;
        m_product = 16'h0;
        forever begin
            @(posedge clk); #1;
            if (m_start && !mdl_never) begin
                p = int'(m_a) * int'(m_b);
                repeat (mdl_delay - 1) @(posedge clk);
                @(posedge clk); #1;
                m_done    = 1'b1;
                m_product = 16'(p);
                @(posedge clk); #1;
                m_done    = 1'b0;
                m_product = 16'hDEAD;
            end
        end
    end

    int cyc = 0;
    int t_start = 0, t_mstart = 0, t_mdone = 0, t_done = 0;
    int mstart_cnt = 0;
    logic prev_mdone = 1'b0, prev_done = 1'b0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(negedge clk);
        if (m_start) begin
            mstart_cnt++;
            t_mstart = cyc;
        end
        if (m_done && !prev_mdone) t_mdone = cyc;
        if (done && !prev_done)    t_done  = cyc;
        prev_mdone = m_done;
        prev_done  = done;
    end

    task automatic do_start(input logic [7:0] a, input logic [7:0] b, input bit push);
        exp_t e;
        int sa, sbv, prod, mag;
        @(posedge clk); #1;
        plicand = a;
        pliar   = b;
        start   = 1'b1;
        t_start = cyc;
        if (push) begin
            sa     = int'($signed(a));
            sbv    = int'($signed(b));
            prod   = sa * sbv;
            mag    = (prod < 0) ? -prod : prod;
            e.ea   = 8'((sa  < 0) ? -sa  : sa);
            e.eb   = 8'((sbv < 0) ? -sbv : sbv);
            e.eerr = mdl_never;
            e.es   = mdl_never ? 1'b0 : (prod < 0);
            e.ebcd = mdl_never ? exp_bcd(0) : exp_bcd(mag);
            scb.push_back(e);
        end
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        exp_t e;
        int n;
        n = 0;
        check({tag, "_busy_run"}, 32'({busy, done}), 32'b10);
        while (!done && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            check({tag, "_done_timeout"}, 32'(done), 32'd1);
            if (scb.size() > 0) void'(scb.pop_front());
            return;
        end
        if (scb.size() == 0) begin
            check({tag, "_scb_empty"}, 32'(scb.size()), 32'd1);
            return;
        end
        e = scb.pop_front();
        check({tag, "_mab"},  32'({m_a, m_b}), 32'({e.ea, e.eb}));
        check({tag, "_sign"}, 32'(sign), 32'(e.es));
        check({tag, "_bcd"},  32'(bcd),  32'(e.ebcd));
        check({tag, "_err"},  32'(err),  32'(e.eerr));
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic pulse_scroll(input logic l, input logic r, input logic exp, input string tag);
        @(posedge clk); #1;
        SL = l;
        SR = r;
        @(posedge clk); #1;
        SL = 1'b0;
        SR = 1'b0;
        check(tag, 32'(scroll), 32'(exp));
    endtask

    initial begin
        logic [7:0] ra, rb;
        int n;
        rst = 1'b0; start = 1'b0; SL = 1'b0; SR = 1'b0;
        plicand = 8'h0; pliar = 8'h0;
        repeat (3) @(posedge clk); #1;
        check("rst_mab",   32'({m_a, m_b}), 32'd0);
        check("rst_bcd",   32'(bcd), 32'd0);
        check("rst_flags", 32'({m_start, busy, done, sign, scroll, err}), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        mdl_delay = 5;
        do_start(8'h0C, 8'hFD, 1'b1);
        wait_done("t1");
        check("t1_lat_mstart", 32'(t_mstart - t_start), 32'd2);
        check("t1_lat_done",   32'(t_done - t_mdone),   32'd17);

        do_start(8'h80, 8'h80, 1'b1);
        wait_done("t2");

        do_start(8'h00, 8'hFB, 1'b1);
        wait_done("t3");

        mdl_never = 1'b1;
        do_start(8'h05, 8'h07, 1'b1);
        wait_done("t4to");
        check("t4_lat_timeout", 32'(t_done - t_mstart), 32'd64);
        mdl_never = 1'b0;

        do_start(8'h7F, 8'h81, 1'b1);
        check("t5_err_clr", 32'({err, done}), 32'd0);
        wait_done("t5");

        for (int k = 0; k < 4; k++) begin
            mdl_delay = int'($urandom_range(1, 12));
            ra = 8'($urandom);
            rb = 8'($urandom);
            do_start(ra, rb, 1'b1);
            wait_done("rnd");
        end

        // Reset during conversion; extra starts in WAIT and CONV must be ignored.
        mdl_delay  = 5;
        mstart_cnt = 0;
        do_start(8'h0C, 8'hFD, 1'b0);
        n = 0;
        while (!m_start && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("rs_mstart_seen", 32'(m_start), 32'd1);
        @(posedge clk); #1;
        plicand = 8'h11;
        start   = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
        n = 0;
        while (!m_done && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("rs_mdone_seen", 32'(m_done), 32'd1);
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #2;
        check("rs_conv_busy", 32'({busy, done}), 32'b10);
        check("rs_one_mstart", 32'(mstart_cnt), 32'd1);
        check("rs_ma_kept", 32'(m_a), 32'h0C);
        rst = 1'b0;
        #1;
        check("rs_mab",   32'({m_a, m_b}), 32'd0);
        check("rs_bcd",   32'(bcd), 32'd0);
        check("rs_flags", 32'({m_start, busy, done, sign, scroll, err}), 32'd0);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        @(posedge clk); #1;

        pulse_scroll(1'b1, 1'b0, 1'b1, "sc_sl");
        pulse_scroll(1'b1, 1'b0, 1'b1, "sc_sl_sat");
        pulse_scroll(1'b1, 1'b1, 1'b1, "sc_both");
        pulse_scroll(1'b0, 1'b1, 1'b0, "sc_sr");
        pulse_scroll(1'b0, 1'b1, 1'b0, "sc_sr_sat");
        pulse_scroll(1'b1, 1'b0, 1'b1, "sc_sl2");
        do_start(8'h03, 8'h04, 1'b1);
        check("sc_start_clr", 32'(scroll), 32'd0);
        wait_done("t6");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
